// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display stage.
//   - FSM state encoding for the serial binary-to-BCD converter
//   - Active-low 7-segment glyph constants, ordered {g,f,e,d,c,b,a}
//   - Result/BCD widths and one double-dabble iteration as a helper
package calc_pkg;

  localparam int RES_W = 14;            // calculator magnitude width
  localparam int BCD_W = 20;            // 5 BCD nibbles
  localparam int SH_W  = BCD_W + RES_W; // double-dabble shift register

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // One double-dabble iteration: every BCD nibble >= 5 gets +3, then the
  // whole register shifts left by one. A nibble never exceeds 9 before the
  // correction, so the +3 always fits in 4 bits.
  function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] s);
    logic [SH_W-1:0] t;
    t = s;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (t[RES_W + 4*k +: 4] >= 4'd5)
        t[RES_W + 4*k +: 4] = t[RES_W + 4*k +: 4] + 4'd3;
    end
    return {t[SH_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/display_resultado_if.sv
// Bus between the calculator and its display stage.
//   Y      14  unsigned magnitude from the calculator
//   sinal  1   1 = negative result
//   EN     1   calculator powered; 0 = display dark
//   seg    7   {g,f,e,d,c,b,a}, active-low
//   an     6   active-low one-hot digit enables, an[5] = sign digit
//   bcd    20  last completed conversion, bcd[3:0] = units
//   valid  1   bcd/display hold a completed conversion for this EN session
//   busy   1   conversion in progress
// master = calculator side, slave = display stage.
interface display_resultado_if;
  import calc_pkg::*;

  logic [RES_W-1:0] Y;
  logic             sinal;
  logic             EN;
  logic [6:0]       seg;
  logic [5:0]       an;
  logic [BCD_W-1:0] bcd;
  logic             valid;
  logic             busy;

  modport master (
    output Y, sinal, EN,
    input  seg, an, bcd, valid, busy
  );

  modport slave (
    input  Y, sinal, EN,
    output seg, an, bcd, valid, busy
  );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment glyph.
//   nibble  in  4  BCD digit; values above 9 render blank
//   blank   in  1  force the digit dark (leading-zero suppression)
//   glyph   out 7  {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] glyph
);

  // NOTE: glyph gets a default before the case so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    glyph = SEG_BLANK;
    if (!blank) begin
      unique case (nibble)
        4'd0:    glyph = SEG_0;
        4'd1:    glyph = SEG_1;
        4'd2:    glyph = SEG_2;
        4'd3:    glyph = SEG_3;
        4'd4:    glyph = SEG_4;
        4'd5:    glyph = SEG_5;
        4'd6:    glyph = SEG_6;
        4'd7:    glyph = SEG_7;
        4'd8:    glyph = SEG_8;
        4'd9:    glyph = SEG_9;
        default: glyph = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/display_resultado.sv
// Display stage of the calculator.
// Converts the 14-bit result to 5 BCD digits with a serial double-dabble
// engine (one iteration per clock, 15 clocks from sampling to bcd/valid) and
// scans a 6-digit active-low 7-segment display: 5 magnitude digits with
// leading-zero blanking plus a sign digit.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous reset, active-high
//   bus  slave side of display_resultado_if (Y, sinal, EN in;
//        seg, an, bcd, valid, busy out)
// SCAN_DIV: clocks each digit stays lit, must be >= 2.
module display_resultado
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input logic                clk,
  input logic                rst,
  display_resultado_if.slave bus
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_t           state, state_nxt;
  logic             start;
  logic [SH_W-1:0]  shreg;
  logic [3:0]       cnt;
  logic [RES_W-1:0] y_last;
  logic             s_last;
  logic             stale;
  logic             sign_q;
  logic [BCD_W-1:0] bcd_q;
  logic             valid_q;
  logic [PW-1:0]    presc;
  logic [2:0]       idx;
  logic [5:0]       an_q;
  logic [6:0]       seg_q;

  logic [3:0]       nib;
  logic             nib_blank;
  logic [6:0]       glyph;
  logic [6:0]       seg_nxt;

  // ---------------------------------------------------------------- FSM
  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A new conversion starts only while powered and when the input differs
  // from what was last converted, or when the previous result was dropped.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.EN && (stale || bus.Y != y_last || bus.sinal != s_last)) begin
          start     = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: if (cnt == 4'(RES_W - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      cnt     <= '0;
      y_last  <= '0;
      s_last  <= 1'b0;
      stale   <= 1'b1;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (start) begin
        shreg  <= {{BCD_W{1'b0}}, bus.Y};
        y_last <= bus.Y;
        s_last <= bus.sinal;
        cnt    <= '0;
        stale  <= 1'b0;
      end else if (state == ST_SHIFT) begin
        shreg <= dabble_step(shreg);
        cnt   <= cnt + 4'd1;
      end else if (state == ST_DONE) begin
        bcd_q  <= shreg[SH_W-1:RES_W];
        sign_q <= s_last;
        // A conversion that was in flight when EN dropped left stale set;
        // its result is never shown, IDLE reconverts instead.
        valid_q <= !stale;
      end
      // Powering down overrides anything above on the same edge.
      if (!bus.EN) begin
        valid_q <= 1'b0;
        stale   <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------- scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Digit k (1..4) is blanked when it and every higher digit are zero.
  always_comb begin
    nib       = 4'd0;
    nib_blank = 1'b1;
    unique case (idx)
      3'd0: begin nib = bcd_q[3:0];   nib_blank = 1'b0;                end
      3'd1: begin nib = bcd_q[7:4];   nib_blank = (bcd_q[19:4]  == '0); end
      3'd2: begin nib = bcd_q[11:8];  nib_blank = (bcd_q[19:8]  == '0); end
      3'd3: begin nib = bcd_q[15:12]; nib_blank = (bcd_q[19:12] == '0); end
      3'd4: begin nib = bcd_q[19:16]; nib_blank = (bcd_q[19:16] == '0); end
      default: begin nib = 4'd0;      nib_blank = 1'b1;                end
    endcase
  end

  seg7_decoder u_dec (
    .nibble (nib),
    .blank  (nib_blank),
    .glyph  (glyph)
  );

  // Sign digit shows '-' only for a nonzero negative result.
  always_comb begin
    seg_nxt = glyph;
    if (idx == 3'd5)
      seg_nxt = (sign_q && bcd_q != '0) ? SEG_MINUS : SEG_BLANK;
  end

  // Anode and segment drive are registered together so they switch on the
  // same edge and no digit ever shows its neighbour's glyph.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 6'b111111;
      seg_q <= SEG_BLANK;
    end else if (bus.EN && valid_q) begin
      an_q  <= ~(6'b000001 << idx);
      seg_q <= seg_nxt;
    end else begin
      an_q  <= 6'b111111;
      seg_q <= SEG_BLANK;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.an    = an_q;
  assign bus.bcd   = bcd_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_display_resultado.sv
// Self-checking bench for display_resultado. Expected BCD values are pushed
// to a scoreboard when a conversion is requested and popped when the DUT
// finishes one (busy falling); glyphs come from an independent decimal model.
module tb_display_resultado;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_resultado_if bus_if ();

  display_resultado #(.SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [19:0] exp_q[$];
  logic        prev_busy = 1'b0;
  logic [19:0] prev_bcd = '0;
  logic [19:0] exp_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph_of(input int d);
    logic [6:0] tbl[10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  function automatic logic [6:0] exp_digit(input int y, input bit s, input int k);
    int p;
    if (k == 5) return (s && y != 0) ? 7'b0111111 : 7'b1111111;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && y < p) return 7'b1111111;
    return glyph_of((y / p) % 10);
  endfunction

  // Completion monitor: checks popped expectations and that bcd never moves
  // except at a completion.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_busy = 1'b0;
      prev_bcd  = '0;
    end else begin
      if (prev_busy && !bus_if.busy) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected", bus_if.bcd, 20'hFFFFF);
        end else begin
          exp_val = exp_q.pop_front();
          check("bcd", bus_if.bcd, exp_val);
          check("valid_done", bus_if.valid, 1);
        end
      end else begin
        check("bcd_hold", bus_if.bcd, prev_bcd);
      end
      prev_busy = bus_if.busy;
      prev_bcd  = bus_if.bcd;
    end
  end

  // Counts rising edges until the next completion; exp_edges includes the
  // completing edge.
  task automatic wait_conv(input int exp_edges, input string tag);
    int start_cnt = done_cnt;
    int n = 0;
    while (done_cnt == start_cnt && n < 40) begin
      @(posedge clk);
      n++;
      #2;
    end
    check(tag, n, exp_edges);
  endtask

  task automatic check_scan(input int y, input bit s);
    logic [5:0] want;
    int n;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      want = ~(6'b000001 << k);
      n = 0;
      while (bus_if.an !== want && n < 100) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("an%0d_seen", k), (n < 100), 1);
      check($sformatf("seg_d%0d_y%0d", k, y), bus_if.seg, exp_digit(y, s, k));
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_an"},    bus_if.an,    6'b111111);
    check({tag, "_seg"},   bus_if.seg,   7'b1111111);
    check({tag, "_valid"}, bus_if.valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus_if.EN = 1'b1;
    bus_if.Y = '0;
    bus_if.sinal = 1'b0;
    repeat (3) @(negedge clk);
    check_dark("reset");
    check("reset_bcd",  bus_if.bcd,  0);
    check("reset_busy", bus_if.busy, 0);

    // 1: zero after reset; stale flag forces the first conversion
    exp_q.push_back(to_bcd(0));
    rst = 1'b0;
    wait_conv(16, "lat_t1");
    check_scan(0, 1'b0);

    // 2: largest square of 127
    @(negedge clk);
    bus_if.Y = 14'd16129;
    exp_q.push_back(to_bcd(16129));
    wait_conv(16, "lat_t2");
    check_scan(16129, 1'b0);

    // 3: negative single digit
    @(negedge clk);
    bus_if.Y = 14'd5;
    bus_if.sinal = 1'b1;
    exp_q.push_back(to_bcd(5));
    wait_conv(16, "lat_t3");
    check_scan(5, 1'b1);

    // 4: input changes mid-flight; only completed values appear
    @(negedge clk);
    bus_if.Y = 14'd100;
    bus_if.sinal = 1'b0;
    exp_q.push_back(to_bcd(100));
    repeat (5) @(negedge clk);
    check("busy_t4", bus_if.busy, 1);
    bus_if.Y = 14'd200;
    exp_q.push_back(to_bcd(200));
    wait_conv(11, "lat_t4a");
    wait_conv(16, "lat_t4b");
    check_scan(200, 1'b0);

    // 5: EN drop blanks on the next edge; re-enable reconverts same Y
    @(negedge clk);
    bus_if.Y = 14'd42;
    exp_q.push_back(to_bcd(42));
    wait_conv(16, "lat_t5a");
    @(negedge clk);
    bus_if.EN = 1'b0;
    @(posedge clk);
    #1;
    check_dark("en_off");
    @(negedge clk);
    bus_if.EN = 1'b1;
    exp_q.push_back(to_bcd(42));
    wait_conv(16, "lat_t5b");
    check("valid_t5", bus_if.valid, 1);
    check_scan(42, 1'b0);

    // 6: asynchronous reset in the middle of SHIFT
    @(negedge clk);
    bus_if.Y = 14'd1234;
    repeat (8) @(posedge clk);
    #1;
    check("busy_t6", bus_if.busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_dark("midrst");
    check("midrst_bcd",  bus_if.bcd,  0);
    check("midrst_busy", bus_if.busy, 0);
    @(negedge clk);
    bus_if.Y = 14'd9999;
    @(negedge clk);
    exp_q.push_back(to_bcd(9999));
    rst = 1'b0;
    wait_conv(16, "lat_t6");
    check_scan(9999, 1'b0);

    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
